// File: rtl/fp_accumulator.sv
// Streaming floating-point accumulator: sums a stream of terms into one result per
// in_last-terminated row, using an internal truncating adder (acc first, term second).
module fp_accumulator #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23,
  parameter int CNT_W    = 8,
  parameter int W        = EXPONENT + MANTISSA + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and payload is only looked at on a transfer.

  localparam int G   = 3;
  localparam int FW  = MANTISSA + 1 + G;
  localparam int LZW = $clog2(FW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  // ---------------------------------------------------------------- adder
  logic                swap;
  logic [W-1:0]        x, y;
  logic                x_s, y_s;
  logic [EXPONENT-1:0] x_e, y_e, d;
  logic [FW-1:0]       x_m, y_m, y_sh, m_norm;
  logic [FW:0]         s;
  logic [LZW-1:0]      lz;
  logic [EXPONENT:0]   lz_ext, e_res;
  logic                found;
  logic [W-1:0]        sum;
  logic                unused_bits;

  always_comb begin
    swap   = in_data[W-2:0] > acc[W-2:0];
    x      = swap ? in_data : acc;
    y      = swap ? acc : in_data;
    x_s    = x[W-1];
    y_s    = y[W-1];
    x_e    = x[W-2:MANTISSA];
    y_e    = y[W-2:MANTISSA];
    x_m    = {(x_e != '0), x[MANTISSA-1:0], {G{1'b0}}};
    y_m    = {(y_e != '0), y[MANTISSA-1:0], {G{1'b0}}};
    d      = x_e - y_e;
    y_sh   = y_m >> d;
    s      = '0;
    m_norm = '0;
    e_res  = '0;
    lz     = '0;
    found  = 1'b0;
    sum    = x;
    // A zero (or flushed subnormal) smaller operand leaves the larger one untouched.
    if (y_e != '0) begin
      if (x_s == y_s) begin
        s = {1'b0, x_m} + {1'b0, y_sh};
        if (s[FW]) begin
          m_norm = s[FW:1];
          e_res  = {1'b0, x_e} + {{EXPONENT{1'b0}}, 1'b1};
        end else begin
          m_norm = s[FW-1:0];
          e_res  = {1'b0, x_e};
        end
        sum = {x_s, e_res[EXPONENT-1:0], m_norm[FW-2:G]};
      end else begin
        s = {1'b0, x_m - y_sh};
        for (int i = FW - 1; i >= 0; i--) begin
          if (!found && s[i]) begin
            found = 1'b1;
            lz    = LZW'(FW - 1 - i);
          end
        end
        if (!found || ({{(EXPONENT+1-LZW){1'b0}}, lz} >= {1'b0, x_e})) begin
          sum = '0;
        end else begin
          m_norm = s[FW-1:0] << lz;
          e_res  = {1'b0, x_e} - {{(EXPONENT+1-LZW){1'b0}}, lz};
          sum    = {x_s, e_res[EXPONENT-1:0], m_norm[FW-2:G]};
        end
      end
    end
  end

  assign lz_ext      = {{(EXPONENT+1-LZW){1'b0}}, lz};
  assign unused_bits = ^{m_norm[FW-1], m_norm[G-1:0], e_res[EXPONENT], lz_ext};

  // ---------------------------------------------------------------- next values
  logic [W-1:0]     acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;
  logic             accept;
  logic             cnt_max;

  always_comb begin
    cnt_max = (cnt == {CNT_W{1'b1}});
    accept  = in_valid & in_ready;
    if (state == IDLE) begin
      acc_next = in_data;
      cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
      sat_next = 1'b0;
    end else begin
      acc_next = sum;
      cnt_next = cnt_max ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      sat_next = sat | cnt_max;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc  <= acc_next;
            cnt  <= cnt_next;
            sat  <= sat_next;
            busy <= 1'b1;
            if (in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= acc_next;
              out_count <= cnt_next;
              out_sat   <= sat_next;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: main instance with CNT_W = 8 and a second
// instance with CNT_W = 2 for counter saturation.
module tb_fp_accumulator;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // main instance
  logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, out_sat, busy;
  logic [W-1:0] out_data;
  logic [7:0]   out_count;
  logic [1:0]   state_dbg;

  fp_accumulator #(.EXPONENT(8), .MANTISSA(23), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_sat(out_sat), .busy(busy), .state_dbg(state_dbg)
  );

  // saturation instance
  logic         b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
  logic [W-1:0] b_in_data = '0;
  logic         b_in_ready, b_out_valid, b_out_sat, b_busy;
  logic [W-1:0] b_out_data;
  logic [1:0]   b_out_count;
  logic [1:0]   b_state_dbg;

  fp_accumulator #(.EXPONENT(8), .MANTISSA(23), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_count(b_out_count), .out_sat(b_out_sat), .busy(b_busy), .state_dbg(b_state_dbg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [W-1:0] data, input logic last);
    b_in_valid = 1'b1;
    b_in_data  = data;
    b_in_last  = last;
    step();
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_data"},  64'(out_data), 64'd0);
    chk({tag, "_count"}, 64'(out_count), 64'd0);
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] d, input logic [7:0] c);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  64'(out_data), 64'(d));
    chk({tag, "_count"}, 64'(out_count), 64'(c));
    chk({tag, "_sat"},   64'(out_sat), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step();
    step();
    chk_idle("reset_held");
    rst = 1'b0;
    step();
    chk_idle("reset_release");

    // four ones back-to-back -> 4.0
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b0);
    chk("ones_pre_valid", 64'(out_valid), 64'd0);
    chk("ones_pre_busy",  64'(busy), 64'd1);
    chk("ones_pre_data",  64'(out_data), 64'd0);
    send(32'h3F800000, 1'b1);
    chk_out("ones", 32'h40800000, 8'd4);
    drain();
    chk_idle("ones_drain");

    // 3.0, gap of 3 cycles (with stray in_last and out_ready), then -1.0 -> 2.0
    send(32'h40400000, 1'b0);
    in_last   = 1'b1;
    out_ready = 1'b1;
    step();
    in_last   = 1'b0;
    step();
    out_ready = 1'b0;
    step();
    chk("gap_valid", 64'(out_valid), 64'd0);
    chk("gap_busy",  64'(busy), 64'd1);
    chk("gap_ready", 64'(in_ready), 64'd1);
    send(32'hBF800000, 1'b1);
    chk_out("gap", 32'h40000000, 8'd2);
    drain();

    // single term, then stall in HOLD while a term is offered
    send(32'h3F000000, 1'b1);
    chk_out("single", 32'h3F000000, 8'd1);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_data",  64'(out_data), 64'h3F000000);
      chk("stall_count", 64'(out_count), 64'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_release_ready", 64'(in_ready), 64'd1);
    chk("stall_release_valid", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_out("next_sum", 32'h40000000, 8'd1);
    drain();

    // negative zero passes through unchanged on a single-term sum
    send(32'h80000000, 1'b1);
    chk_out("neg_zero", 32'h80000000, 8'd1);
    drain();

    // reset in HOLD drops out_valid without a handshake
    send(32'h3F800000, 1'b1);
    chk("hold_rst_pre", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk_idle("hold_rst");
    step();
    rst = 1'b0;
    step();

    // reset mid-sum discards the partial sum
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b0);
    rst = 1'b1;
    #1;
    chk_idle("acc_rst");
    step();
    rst = 1'b0;
    send(32'h3F800000, 1'b1);
    chk_out("after_rst", 32'h3F800000, 8'd1);
    drain();

    // counter saturation on the CNT_W = 2 instance
    send_b(32'h3F800000, 1'b0);
    send_b(32'h3F800000, 1'b0);
    send_b(32'h3F800000, 1'b1);
    chk("b3_data",  64'(b_out_data), 64'h40400000);
    chk("b3_count", 64'(b_out_count), 64'd3);
    chk("b3_sat",   64'(b_out_sat), 64'd0);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_b(32'h3F800000, 1'b0);
    send_b(32'h3F800000, 1'b1);
    chk("b5_valid", 64'(b_out_valid), 64'd1);
    chk("b5_data",  64'(b_out_data), 64'h40A00000);
    chk("b5_count", 64'(b_out_count), 64'd3);
    chk("b5_sat",   64'(b_out_sat), 64'd1);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("b_drain_sat",  64'(b_out_sat), 64'd0);
    chk("b_drain_busy", 64'(b_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
